// File: rtl/sap_cpu_core.sv
// Multi-cycle SAP-style accumulator CPU with parametrised data/address widths,
// host program-load port, carry/zero flags, conditional jumps, STA and LDI.
module sap_cpu_core #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          halted,
  output logic          carry,
  output logic          zero
);

  typedef enum logic [2:0] {
    S_IDLE, S_HALT, S_T1, S_T2, S_T3, S_T4, S_T5
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_LDI = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JC  = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] mar_q, mar_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          halted_q, halted_d;
  logic          carry_q, carry_d;
  logic          zero_q, zero_d;

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] ram_rdata;
  logic          host_we, sta_we, ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;

  logic [3:0]    opcode;
  logic [AW-1:0] operand;
  logic [DW:0]   sum_ext, diff_ext;
  logic          stopped;

  assign opcode    = ir_q[DW-1 -: 4];
  assign operand   = ir_q[AW-1:0];
  assign ram_rdata = mem[mar_q];
  assign sum_ext   = {1'b0, a_q} + {1'b0, b_q};
  assign diff_ext  = {1'b0, a_q} - {1'b0, b_q};
  assign stopped   = (state_q == S_IDLE) || (state_q == S_HALT);
  assign host_we   = prog_we && stopped;
  assign ram_we    = host_we || sta_we;
  assign ram_waddr = host_we ? prog_addr : mar_q;
  assign ram_wdata = host_we ? prog_data : a_q;

  // NOTE: every signal gets a default before the case, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mar_d       = mar_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    halted_d    = halted_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    sta_we      = 1'b0;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (run) begin
          pc_d     = '0;
          halted_d = 1'b0;
          state_d  = S_T1;
        end
      end
      S_T1: begin
        mar_d   = pc_q;
        state_d = S_T2;
      end
      S_T2: begin
        ir_d    = ram_rdata;
        pc_d    = pc_q + 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        state_d = S_T1;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            mar_d   = operand;
            state_d = S_T4;
          end
          OP_LDI: a_d = {{(DW-AW){1'b0}}, operand};
          OP_JMP: pc_d = operand;
          OP_JC:  if (carry_q) pc_d = operand;
          OP_JZ:  if (zero_q)  pc_d = operand;
          OP_OUT: begin
            out_data_d  = a_q;
            out_valid_d = 1'b1;
          end
          OP_HLT: begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
          default: ;
        endcase
      end
      S_T4: begin
        state_d = S_T1;
        if (opcode == OP_LDA) begin
          a_d = ram_rdata;
        end else if (opcode == OP_STA) begin
          sta_we = 1'b1;
        end else begin
          b_d     = ram_rdata;
          state_d = S_T5;
        end
      end
      S_T5: begin
        state_d = S_T1;
        if (opcode == OP_ADD) begin
          a_d     = sum_ext[DW-1:0];
          carry_d = sum_ext[DW];
          zero_d  = (sum_ext[DW-1:0] == '0);
        end else begin
          // carry holds "no borrow", i.e. A >= B unsigned
          a_d     = diff_ext[DW-1:0];
          carry_d = ~diff_ext[DW];
          zero_d  = (diff_ext[DW-1:0] == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // sees pre-edge values of the others regardless of evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      mar_q       <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mar_q       <= mar_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
    end
  end

  // NOTE: the RAM has no reset so it maps onto plain memory; an in-flight STA
  // cannot write during reset because the state register is already IDLE.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign halted    = halted_q;
  assign carry     = carry_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_sap_cpu_core.sv
// Scoreboard bench for sap_cpu_core: an 8/4 instance for the main programs and
// a 12/8 instance for wide-word and PC-wrap behaviour.
module tb_sap_cpu_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        run, prog_we;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [7:0]  out_data;
  logic        out_valid, halted, carry, zero;

  logic        run12, p12_we;
  logic [7:0]  p12_addr;
  logic [11:0] p12_data;
  logic [11:0] out12;
  logic        valid12, halted12, carry12, zero12;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [11:0] exp12_q[$];

  always #5 clk = ~clk;

  sap_cpu_core #(.DW(8), .AW(4)) dut (
    .clk(clk), .reset(reset), .run(run), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .out_data(out_data),
    .out_valid(out_valid), .halted(halted), .carry(carry), .zero(zero)
  );

  sap_cpu_core #(.DW(12), .AW(8)) dut12 (
    .clk(clk), .reset(reset), .run(run12), .prog_we(p12_we),
    .prog_addr(p12_addr), .prog_data(p12_data), .out_data(out12),
    .out_valid(valid12), .halted(halted12), .carry(carry12), .zero(zero12)
  );

  always @(negedge clk) begin
    logic [7:0] e;
    if (out_valid === 1'b1) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL out8_unexpected: got %h, no value expected", out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) $display("FAIL out8: got %h expected %h", out_data, e);
        else pass_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    logic [11:0] e;
    if (valid12 === 1'b1) begin
      total_cnt++;
      if (exp12_q.size() == 0) begin
        $display("FAIL out12_unexpected: got %h, no value expected", out12);
      end else begin
        e = exp12_q.pop_front();
        if (out12 !== e) $display("FAIL out12: got %h expected %h", out12, e);
        else pass_cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pw(input logic [3:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic pw12(input logic [7:0] a, input logic [11:0] d);
    p12_we = 1'b1; p12_addr = a; p12_data = d;
    @(negedge clk);
    p12_we = 1'b0;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  // Counts rising edges from the run edge until halted is seen high.
  task automatic wait_halt(input bit wide, output int cycles);
    cycles = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((wide ? halted12 : halted) === 1'b1) begin
        cycles = i + 1;
        break;
      end
    end
    if (cycles < 0) begin
      total_cnt++;
      $display("FAIL halt_timeout: got no halt, required halt within 400 cycles");
    end
  endtask

  task automatic expect_drained(input string name);
    total_cnt++;
    if (exp_q.size() !== 0)
      $display("FAIL %s_drain: got %0d pending outputs, required 0", name, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic expect_flags(input string name, input logic c, input logic z);
    total_cnt++;
    if ({carry, zero, halted} !== {c, z, 1'b1})
      $display("FAIL %s_flags: got c/z/h %b%b%b required %b%b1", name, carry, zero, halted, c, z);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b0; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    run12 = 1'b0; p12_we = 1'b0; p12_addr = '0; p12_data = '0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({out_data, out_valid, halted, carry, zero} !== 12'h000)
      $display("FAIL reset8: got %h/%b%b%b%b required all zero", out_data, out_valid, halted, carry, zero);
    else pass_cnt++;
    total_cnt++;
    if ({out12, valid12, halted12, carry12, zero12} !== 16'h0000)
      $display("FAIL reset12: got %h/%b%b%b%b required all zero", out12, valid12, halted12, carry12, zero12);
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_program();
    int cyc;
    pw(4'h1, 8'h1A); pw(4'h2, 8'hE0); pw(4'h3, 8'hF0);
    pw(4'h9, 8'h05); pw(4'hA, 8'h03);
    exp_q.push_back(8'h08);
    run = 1'b1;
    pw(4'h0, 8'h09);  // written on the same edge that accepts run
    run = 1'b0;
    wait_halt(1'b0, cyc);
    total_cnt++;
    if (cyc !== 15) $display("FAIL halt_latency: got %0d cycles required 15", cyc);
    else pass_cnt++;
    total_cnt++;
    if (out_data !== 8'h08) $display("FAIL prog_out: got %h required 08", out_data);
    else pass_cnt++;
    expect_flags("prog", 1'b0, 1'b0);
    expect_drained("prog");
  endtask

  task automatic test_alu();
    logic [7:0] ta [4] = '{8'h03, 8'h05, 8'hFF, 8'h10};
    logic [7:0] tb [4] = '{8'h05, 8'h05, 8'h01, 8'h20};
    logic [7:0] ti [4] = '{8'h29, 8'h29, 8'h19, 8'h19};
    logic [7:0] tr [4] = '{8'hFE, 8'h00, 8'h00, 8'h30};
    logic [1:0] tf [4] = '{2'b00, 2'b11, 2'b11, 2'b00};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      pw(4'h0, 8'h08); pw(4'h1, ti[i]); pw(4'h2, 8'hE0); pw(4'h3, 8'hF0);
      pw(4'h8, ta[i]); pw(4'h9, tb[i]);
      exp_q.push_back(tr[i]);
      pulse_run();
      wait_halt(1'b0, cyc);
      expect_flags("alu", tf[i][1], tf[i][0]);
    end
    expect_drained("alu");
  endtask

  task automatic test_countdown();
    int cyc;
    pw(4'h0, 8'h43); pw(4'h1, 8'h26); pw(4'h2, 8'hE0); pw(4'h3, 8'h75);
    pw(4'h4, 8'h51); pw(4'h5, 8'hF0); pw(4'h6, 8'h01);
    exp_q.push_back(8'h02); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    pulse_run();
    wait_halt(1'b0, cyc);
    expect_flags("countdown", 1'b1, 1'b1);
    expect_drained("countdown");
  endtask

  task automatic test_jc();
    int cyc;
    pw(4'h0, 8'h41); pw(4'h1, 8'h28); pw(4'h2, 8'h66); pw(4'h3, 8'hE0);
    pw(4'h4, 8'h19); pw(4'h5, 8'h6A); pw(4'h6, 8'hF0);
    pw(4'h8, 8'h02); pw(4'h9, 8'h01);
    pw(4'hA, 8'h44); pw(4'hB, 8'hE0); pw(4'hC, 8'hF0);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h04);
    pulse_run();
    wait_halt(1'b0, cyc);
    expect_flags("jc", 1'b1, 1'b1);
    expect_drained("jc");
  endtask

  task automatic test_sta_lda();
    int cyc;
    pw(4'h0, 8'h46); pw(4'h1, 8'h3F); pw(4'h2, 8'h40); pw(4'h3, 8'h0F);
    pw(4'h4, 8'hE0); pw(4'h5, 8'hF0);
    exp_q.push_back(8'h06);
    pulse_run();
    repeat (8) @(negedge clk);
    pw(4'hF, 8'hAA);  // lands between STA and LDA; must be ignored
    wait_halt(1'b0, cyc);
    total_cnt++;
    if (out_data !== 8'h06) $display("FAIL sta_lda: got %h required 06", out_data);
    else pass_cnt++;
    expect_drained("sta_lda");
  endtask

  task automatic test_reset_mid_sta();
    int cyc;
    pw(4'h0, 8'h49); pw(4'h1, 8'h3E); pw(4'h2, 8'hF0); pw(4'hE, 8'h33);
    pulse_run();
    repeat (6) @(negedge clk);  // LDI takes 3 edges, STA reaches T4 after 3 more
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({out_data, out_valid, halted, carry, zero} !== 12'h000)
      $display("FAIL mid_reset: got %h/%b%b%b%b required all zero", out_data, out_valid, halted, carry, zero);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    pw(4'h0, 8'h0E); pw(4'h1, 8'hE0); pw(4'h2, 8'hF0);
    exp_q.push_back(8'h33);
    pulse_run();
    wait_halt(1'b0, cyc);
    total_cnt++;
    if (cyc !== 10) $display("FAIL restart_latency: got %0d cycles required 10", cyc);
    else pass_cnt++;
    expect_drained("mid_reset");
  endtask

  task automatic test_wide();
    int cyc;
    pw12(8'h00, 12'h710); pw12(8'h01, 12'h5C8);
    pw12(8'hC8, 12'h040); pw12(8'hC9, 12'h141); pw12(8'hCA, 12'hE00);
    pw12(8'hCB, 12'h5FF); pw12(8'hFF, 12'h405);
    pw12(8'h10, 12'hE00); pw12(8'h11, 12'hF00);
    pw12(8'h40, 12'hFFF); pw12(8'h41, 12'h001);
    exp12_q.push_back(12'h000); exp12_q.push_back(12'h005);
    run12 = 1'b1;
    @(negedge clk);
    run12 = 1'b0;
    wait_halt(1'b1, cyc);
    total_cnt++;
    if ({carry12, zero12, halted12} !== 3'b111)
      $display("FAIL wide_flags: got c/z/h %b%b%b required 111", carry12, zero12, halted12);
    else pass_cnt++;
    total_cnt++;
    if (out12 !== 12'h005) $display("FAIL wide_out: got %h required 005", out12);
    else pass_cnt++;
    total_cnt++;
    if (exp12_q.size() !== 0)
      $display("FAIL wide_drain: got %0d pending outputs, required 0", exp12_q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_program();
    test_alu();
    test_countdown();
    test_jc();
    test_sta_lda();
    test_reset_mid_sta();
    test_wide();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sap_cpu_core.md
# sap_cpu_core

Parametrised successor to the 8-bit SAP computer top level. It is a multi-cycle accumulator CPU with these internal parts: PC, MAR, IR, A, B, adder/subtractor, output register and RAM. Over the original it adds generic data and address widths, a host program-load port, carry and zero flags, conditional jumps, a store instruction, an immediate load, and an explicit idle/halt handshake. It is the core instantiated by board-level wrappers and benches.

## Interface
- DW, 8, data/instruction word width; must satisfy DW >= 4 + AW
- AW, 4, address width; RAM depth 2^AW words
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- run  in  1  start request, sampled in IDLE/HALT only
- prog_we  in  1  host RAM write strobe, honoured in IDLE/HALT only
- prog_addr  in  AW  host write address
- prog_data  in  DW  host write data
- out_data  out  DW  output register
- out_valid  out  1  one-cycle pulse when OUT executes
- halted  out  1  high in HALT state
- carry  out  1  carry flag
- zero  out  1  zero flag

## Operation
- Instruction word: opcode = bits [DW-1:DW-4]; operand = bits [AW-1:0]; any middle bits are ignored.
- Opcodes:
  - 0 LDA: A <= RAM[op]
  - 1 ADD: A <= A+B, after B <= RAM[op]
  - 2 SUB: A <= A-B, after B <= RAM[op]
  - 3 STA: RAM[op] <= A
  - 4 LDI: A <= zero-extended op
  - 5 JMP: PC <= op
  - 6 JC: PC <= op if carry
  - 7 JZ: PC <= op if zero
  - E OUT: out_data <= A
  - F HLT
  - All other opcodes: NOP
- States: IDLE, HALT, T1..T5. Reset enters IDLE.
- IDLE/HALT with run=1: PC <= 0, next state T1. A, B, flags and out_data are retained.
- T1: MAR <= PC.
- T2: IR <= RAM[MAR]; PC <= PC+1. PC wraps from 2^AW-1 to 0.
- T3 per opcode:
  - LDA/ADD/SUB/STA: MAR <= op
  - LDI: load A
  - JMP: load PC
  - JC/JZ: load PC if the flag is set
  - OUT: load out_data
  - NOP: no action
  - HLT: next state HALT
  - All except LDA/ADD/SUB/STA/HLT then return to T1.
- T4:
  - LDA: A <= RAM[MAR], then T1
  - STA: RAM[MAR] <= A, then T1
  - ADD/SUB: B <= RAM[MAR], then T5
- T5 (ADD/SUB): A <= result mod 2^DW; then T1.
  - carry = DW-bit carry-out for ADD; for SUB, carry = no-borrow (A >= B, unsigned).
  - zero = (result == 0).
  - Only ADD/SUB update the flags.
- RAM: combinational read, synchronous write. Host writes and STA are the only writers. RAM is not cleared by reset.
- prog_we while the FSM is in T1..T5 is ignored.
- prog_we and run asserted in the same IDLE cycle: both take effect. The write is visible to the first fetch.
- run while running is ignored.

## Timing
- Reset (asserted low, async) clears PC, MAR, IR, A, B, out_data, carry, zero, out_valid and halted to 0, and sets state to IDLE. This applies mid-instruction too: the instruction is abandoned, and a partial STA does not write.
- Cycles per instruction, T1 to next T1:
  - LDI/JMP/JC/JZ/OUT/NOP: 3
  - LDA/STA: 4
  - ADD/SUB: 5
  - HLT: 3, then HALT
- out_valid is high for exactly the cycle after the T3 edge of OUT; out_data is updated on that same edge.
- halted goes high on the T3 edge of HLT and low on the edge that accepts run.
- Flags change only on the T5 edge.
- Conditional jumps sample the flags as they stand at T3.

## Test plan
- Load program {0:LDA 9, 1:ADD A, 2:OUT, 3:HLT}, RAM[9]=05, RAM[A]=03, then pulse run.
  - out_data=08, one out_valid pulse, carry=0, zero=0.
  - halted rises exactly 15 clocks after the run edge.
- SUB cases:
  - A=03, B=05 -> A=FE, carry=0, zero=0.
  - A=05, B=05 -> A=00, carry=1, zero=1.
  - ADD FF+01 -> 00, carry=1, zero=1.
- Countdown loop {LDI 3; SUB one; OUT; JZ halt; JMP 1; HLT}:
  - OUT sequence is 02, 01, 00, then halted.
  - JZ is not taken while zero=0.
- STA then LDA round trip: value stored to RAM[F] is read back by host-visible OUT. A prog_we issued during execution does not alter RAM.
- Assert reset during T4 of STA: all outputs 0, state IDLE, target RAM word unchanged. A subsequent run restarts from PC=0.
- DW=12, AW=8: jump to address C8, with PC wrap from FF to 00 executing RAM[00].
  - 12-bit ADD 0FFF+0001 -> 000, carry=1.
